// File: rtl/rv32i_types.sv
// Shared types for the regfile commit sequencer: the queued write record and the sequencer state.
package rv32i_types;

  // Widest ROB tag a queued record can hold; ROB_DEPTH on the sequencer must not exceed it.
  localparam int ROB_TAG_MAX = 16;

  typedef struct packed {
    logic [4:0]             rd_s;
    logic [31:0]            rd_v;
    logic [ROB_TAG_MAX-1:0] rob;
  } commit_wr_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } seq_state_e;

endpackage

// File: rtl/commit_wr_fifo.sv
// Pending regfile-write queue: up to LANES pushes per cycle in lane order, one pop per cycle,
// occupancy count exported so the producer can budget free slots.
module commit_wr_fifo
  import rv32i_types::*;
#(
  parameter int LANES      = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic       [LANES-1:0]  push_i,
  input  commit_wr_t [LANES-1:0]  push_data_i,
  input  logic                    pop_i,
  output commit_wr_t              head_o,
  output logic       [CNT_W-1:0]  count_o
);

  commit_wr_t       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d, n_push;
  logic [PTR_W-1:0] slot [LANES];
  logic             pop_eff;

  // Compact the pushing lanes onto consecutive slots; pointer arithmetic wraps by width.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional update, so no latch is inferred.
    n_push = '0;
    for (int i = 0; i < LANES; i++) begin
      slot[i] = wr_ptr_q + n_push[PTR_W-1:0];
      if (push_i[i]) n_push = n_push + CNT_W'(1);
    end
  end

  assign pop_eff = pop_i && (count_q != '0);
  assign count_d = count_q + n_push - CNT_W'(pop_eff);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + n_push[PTR_W-1:0];
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop_eff);
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; only entries covered by count_q are ever observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_i[i]) mem_q[slot[i]] <= push_data_i[i];
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/regfile_commit_sequencer.sv
// Serialises multi-lane ROB commits onto the single regfile write port and sequences the
// post-mispredict drain. Optional COMMIT_SEQ_BYPASS_EN sends lane 0 straight out when the queue is empty.
module regfile_commit_sequencer
  import rv32i_types::*;
#(
  parameter int ROB_DEPTH  = 4,
  parameter int LANES      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [LANES-1:0]                 rob_commit_valid,
  input  logic [LANES-1:0]                 rob_commit_we,
  input  logic [LANES-1:0][4:0]            rob_commit_rd_s,
  input  logic [LANES-1:0][31:0]           rob_commit_rd_v,
  input  logic [LANES-1:0][ROB_DEPTH-1:0]  rob_commit_rob,
  output logic                             rob_commit_ready,
  input  logic                             flush_req,
  output logic                             regfile_we,
  output logic [4:0]                       regfile_rd_s,
  output logic [31:0]                      regfile_rd_v,
  output logic [ROB_DEPTH-1:0]             regfile_rob,
  output logic                             regfile_move_flush,
  output logic                             issue_stall
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  seq_state_e             state_q, state_d;
  logic       [LANES-1:0] writing, push;
  commit_wr_t [LANES-1:0] lane_wr;
  commit_wr_t             head;
  logic       [CNT_W-1:0] count, n_wr;
  logic                   accept, q_empty, bypass;
  logic                   unused_head_rob;

  always_comb begin
    n_wr = '0;
    for (int i = 0; i < LANES; i++) begin
      writing[i]      = rob_commit_valid[i] && rob_commit_we[i] && (rob_commit_rd_s[i] != 5'd0);
      lane_wr[i].rd_s = rob_commit_rd_s[i];
      lane_wr[i].rd_v = rob_commit_rd_v[i];
      lane_wr[i].rob  = ROB_TAG_MAX'(rob_commit_rob[i]);
      n_wr            = n_wr + CNT_W'(writing[i]);
    end
  end

  // Free slots come from the registered count only; this cycle's pop is not credited.
  assign q_empty = (count == '0);
  assign accept  = !rst && (state_q == RUN) && ((CNT_W'(FIFO_DEPTH) - count) >= n_wr);

`ifdef COMMIT_SEQ_BYPASS_EN
  assign bypass = accept && q_empty && writing[0];
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    push = accept ? writing : '0;
    if (bypass) push[0] = 1'b0;
  end

  commit_wr_fifo #(
    .LANES      (LANES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (lane_wr),
    .pop_i       (!q_empty),
    .head_o      (head),
    .count_o     (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // DRAIN ends in the cycle the final entry pops; no pushes can arrive while draining.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush_req) state_d = DRAIN;
      DRAIN:   if (count <= CNT_W'(1)) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    rob_commit_ready   = accept;
    issue_stall        = (state_q == DRAIN);
    regfile_move_flush = (state_q == DRAIN) && (count <= CNT_W'(1));
    regfile_we         = 1'b0;
    regfile_rd_s       = '0;
    regfile_rd_v       = '0;
    regfile_rob        = '0;
    if (!q_empty) begin
      regfile_we   = 1'b1;
      regfile_rd_s = head.rd_s;
      regfile_rd_v = head.rd_v;
      regfile_rob  = head.rob[ROB_DEPTH-1:0];
    end else if (bypass) begin
      regfile_we   = 1'b1;
      regfile_rd_s = lane_wr[0].rd_s;
      regfile_rd_v = lane_wr[0].rd_v;
      regfile_rob  = rob_commit_rob[0];
    end
  end

  assign unused_head_rob = ^head.rob;

endmodule

// File: tb/tb_regfile_commit_sequencer.sv
// Self-checking bench for regfile_commit_sequencer: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations. Honours COMMIT_SEQ_BYPASS_EN.
module tb_regfile_commit_sequencer;

  localparam int ROB_DEPTH  = 4;
  localparam int LANES      = 2;
  localparam int FIFO_DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             rob_commit_valid, rob_commit_we;
  logic [1:0][4:0]        rob_commit_rd_s;
  logic [1:0][31:0]       rob_commit_rd_v;
  logic [1:0][3:0]        rob_commit_rob;
  logic                   rob_commit_ready, flush_req;
  logic                   regfile_we, regfile_move_flush, issue_stall;
  logic [4:0]             regfile_rd_s;
  logic [31:0]            regfile_rd_v;
  logic [3:0]             regfile_rob;

  int n_tests = 0;
  int n_fail  = 0;
  int tag_ctr = 0;

  regfile_commit_sequencer #(
    .ROB_DEPTH  (ROB_DEPTH),
    .LANES      (LANES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .rob_commit_valid   (rob_commit_valid),
    .rob_commit_we      (rob_commit_we),
    .rob_commit_rd_s    (rob_commit_rd_s),
    .rob_commit_rd_v    (rob_commit_rd_v),
    .rob_commit_rob     (rob_commit_rob),
    .rob_commit_ready   (rob_commit_ready),
    .flush_req          (flush_req),
    .regfile_we         (regfile_we),
    .regfile_rd_s       (regfile_rd_s),
    .regfile_rd_v       (regfile_rd_v),
    .regfile_rob        (regfile_rob),
    .regfile_move_flush (regfile_move_flush),
    .issue_stall        (issue_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending writes and a draining flag.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] v;
    logic [3:0]  rob;
  } wr_t;

  wr_t mq[$];
  bit  m_drain = 1'b0;

  function automatic bit lane_writes(input int i);
    return rob_commit_valid[i] && rob_commit_we[i] && (rob_commit_rd_s[i] != 5'd0);
  endfunction

  function automatic int writes_presented();
    int n = 0;
    for (int i = 0; i < LANES; i++) if (lane_writes(i)) n++;
    return n;
  endfunction

  function automatic bit model_accepts();
    return !m_drain && ((FIFO_DEPTH - int'(mq.size())) >= writes_presented());
  endfunction

  function automatic bit model_bypass();
`ifdef COMMIT_SEQ_BYPASS_EN
    return model_accepts() && (mq.size() == 0) && lane_writes(0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_drain = 1'b0;
    end else begin
      bit acc, byp;
      acc = model_accepts();
      byp = model_bypass();
      if (mq.size() != 0) void'(mq.pop_front());
      if (acc) begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_writes(i) && !(byp && i == 0))
            mq.push_back('{rob_commit_rd_s[i], rob_commit_rd_v[i], rob_commit_rob[i]});
        end
      end
      m_drain = m_drain ? (mq.size() != 0) : flush_req;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      bit  e_we;
      wr_t e;
      e_we = 1'b0;
      e    = '{default: '0};
      if (mq.size() != 0) begin
        e_we = 1'b1;
        e    = mq[0];
      end else if (model_bypass()) begin
        e_we = 1'b1;
        e    = '{rob_commit_rd_s[0], rob_commit_rd_v[0], rob_commit_rob[0]};
      end
      check("ready",       32'(rob_commit_ready),   32'(model_accepts()));
      check("regfile_we",  32'(regfile_we),         32'(e_we));
      check("regfile_rd",  32'(regfile_rd_s),       32'(e.rd));
      check("regfile_v",   32'(regfile_rd_v),       e.v);
      check("regfile_rob", 32'(regfile_rob),        32'(e.rob));
      check("move_flush",  32'(regfile_move_flush), 32'(m_drain && (mq.size() <= 1)));
      check("issue_stall", 32'(issue_stall),        32'(m_drain));
    end
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [4:0] rd0, input logic [31:0] d0,
                       input logic [4:0] rd1, input logic [31:0] d1, input logic fl);
    rob_commit_valid   = v;
    rob_commit_we      = we;
    rob_commit_rd_s[0] = rd0;
    rob_commit_rd_v[0] = d0;
    rob_commit_rd_s[1] = rd1;
    rob_commit_rd_v[1] = d1;
    rob_commit_rob[0]  = 4'(tag_ctr);
    rob_commit_rob[1]  = 4'(tag_ctr + 1);
    tag_ctr            = tag_ctr + 2;
    flush_req          = fl;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b01, 2'b01, 5'd3, 32'h33, 5'd0, 32'h0, 1'b0);
    at_neg();
    check("rst_ready", 32'(rob_commit_ready),   32'd0);
    check("rst_we",    32'(regfile_we),         32'd0);
    check("rst_mf",    32'(regfile_move_flush), 32'd0);
    check("rst_stall", 32'(issue_stall),        32'd0);
    tick();
    tick();
    rst = 1'b0;
    idle();
    tick();

    // Two writing lanes into an empty queue: x5 then x6 on the following cycles.
    drive(2'b11, 2'b11, 5'd5, 32'h11, 5'd6, 32'h22, 1'b0);
    at_neg();
    check("a_ready", 32'(rob_commit_ready), 32'd1);
`ifndef COMMIT_SEQ_BYPASS_EN
    check("a_we0", 32'(regfile_we), 32'd0);
`endif
    tick();
    idle();
`ifndef COMMIT_SEQ_BYPASS_EN
    at_neg();
    check("a_rd1", 32'(regfile_rd_s), 32'd5);
    check("a_v1",  regfile_rd_v,      32'h11);
    tick();
`endif
    at_neg();
    check("a_rd2", 32'(regfile_rd_s), 32'd6);
    check("a_v2",  regfile_rd_v,      32'h22);
    tick();
    at_neg();
    check("a_we3", 32'(regfile_we), 32'd0);
    repeat (2) tick();

    // Back-pressure: three queued plus two writers stalls until count is 2.
    drive(2'b11, 2'b11, 5'd1, 32'hA1, 5'd2, 32'hA2, 1'b0);
    tick();
    drive(2'b11, 2'b11, 5'd3, 32'hA3, 5'd4, 32'hA4, 1'b0);
    at_neg();
    check("b_ready_cnt2", 32'(rob_commit_ready), 32'd1);
    tick();
    drive(2'b11, 2'b11, 5'd10, 32'hB0, 5'd11, 32'hB1, 1'b0);
`ifndef COMMIT_SEQ_BYPASS_EN
    at_neg();
    check("b_ready_cnt3", 32'(rob_commit_ready), 32'd0);
    tick();
    at_neg();
    check("b_ready_retry", 32'(rob_commit_ready), 32'd1);
`endif
    tick();
    idle();
    repeat (6) tick();

    // Lane 0 is a store, lane 1 writes x7: exactly one write appears.
    drive(2'b11, 2'b10, 5'd8, 32'h88, 5'd7, 32'h77, 1'b0);
    at_neg();
    check("c_ready", 32'(rob_commit_ready), 32'd1);
    tick();
    idle();
    at_neg();
    check("c_we", 32'(regfile_we),   32'd1);
    check("c_rd", 32'(regfile_rd_s), 32'd7);
    check("c_v",  regfile_rd_v,      32'h77);
    tick();
    at_neg();
    check("c_we_after", 32'(regfile_we), 32'd0);
    tick();

    // Flush with three queued: drain, flush pulse on the last pop, flush and lanes ignored meanwhile.
    drive(2'b11, 2'b11, 5'd12, 32'hC0, 5'd13, 32'hC1, 1'b0);
    tick();
    drive(2'b11, 2'b11, 5'd14, 32'hC2, 5'd15, 32'hC3, 1'b0);
    tick();
    drive(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1);
    at_neg();
    check("d_stall0", 32'(issue_stall),        32'd0);
    check("d_mf0",    32'(regfile_move_flush), 32'd0);
    tick();
    drive(2'b11, 2'b11, 5'd16, 32'hD0, 5'd17, 32'hD1, 1'b1);
    at_neg();
    check("d_ready1", 32'(rob_commit_ready),   32'd0);
    check("d_stall1", 32'(issue_stall),        32'd1);
    check("d_mf1",    32'(regfile_move_flush), 32'd0);
    check("d_we1",    32'(regfile_we),         32'd1);
    tick();
    idle();
    at_neg();
    check("d_mf2",    32'(regfile_move_flush), 32'd1);
    check("d_stall2", 32'(issue_stall),        32'd1);
    check("d_rd2",    32'(regfile_rd_s),       32'd15);
    check("d_v2",     regfile_rd_v,            32'hC3);
    tick();
    at_neg();
    check("d_mf3",    32'(regfile_move_flush), 32'd0);
    check("d_stall3", 32'(issue_stall),        32'd0);
    check("d_we3",    32'(regfile_we),         32'd0);
    tick();

    // Flush with nothing queued: one cycle of stall with the flush pulse.
    drive(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1);
    at_neg();
    check("e_mf0", 32'(regfile_move_flush), 32'd0);
    tick();
    idle();
    at_neg();
    check("e_mf1",    32'(regfile_move_flush), 32'd1);
    check("e_stall1", 32'(issue_stall),        32'd1);
    tick();
    at_neg();
    check("e_mf2",    32'(regfile_move_flush), 32'd0);
    check("e_stall2", 32'(issue_stall),        32'd0);
    tick();

    // A write to x0 is accepted but never reaches the port.
    drive(2'b01, 2'b01, 5'd0, 32'hEE, 5'd0, 32'h0, 1'b0);
    at_neg();
    check("f_ready", 32'(rob_commit_ready), 32'd1);
    check("f_we0",   32'(regfile_we),       32'd0);
    tick();
    idle();
    at_neg();
    check("f_we1", 32'(regfile_we), 32'd0);
    tick();

    // Reset while draining discards the queue without a flush pulse.
    drive(2'b11, 2'b11, 5'd20, 32'hE0, 5'd21, 32'hE1, 1'b0);
    tick();
    drive(2'b11, 2'b11, 5'd22, 32'hE2, 5'd23, 32'hE3, 1'b0);
    tick();
    drive(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1);
    tick();
    idle();
    at_neg();
    check("g_stall_pre", 32'(issue_stall), 32'd1);
    rst = 1'b1;
    #1;
    check("g_mf",    32'(regfile_move_flush), 32'd0);
    check("g_stall", 32'(issue_stall),        32'd0);
    check("g_we",    32'(regfile_we),         32'd0);
    check("g_ready", 32'(rob_commit_ready),   32'd0);
    tick();
    rst = 1'b0;
    tick();
    at_neg();
    check("g_we_after",    32'(regfile_we),       32'd0);
    check("g_ready_after", 32'(rob_commit_ready), 32'd1);
    tick();

`ifdef COMMIT_SEQ_BYPASS_EN
    drive(2'b01, 2'b01, 5'd9, 32'hAB, 5'd0, 32'h0, 1'b0);
    at_neg();
    check("h_we", 32'(regfile_we),   32'd1);
    check("h_rd", 32'(regfile_rd_s), 32'd9);
    check("h_v",  regfile_rd_v,      32'hAB);
    tick();
    idle();
    at_neg();
    check("h_we_after", 32'(regfile_we), 32'd0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
